// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: shared types and constants for the PS/2 keyboard mailbox writer.
//   rx_state_t  - PS/2 frame receiver states
//   wr_state_t  - mailbox writer states
//   make_event  - packs a decoded key into the mailbox event word
package ps2_kb_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    W_IDLE,
    W_HOLD
  } wr_state_t;

  localparam logic [7:0] EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  localparam int VALID_BIT = 31;
  localparam int EXT_BIT   = 9;
  localparam int BRK_BIT   = 8;

  // The valid bit keeps every event word nonzero, so a zero mailbox
  // always means "consumed".
  function automatic logic [31:0] make_event(input logic ext, input logic brk,
                                             input logic [7:0] code);
    logic [31:0] ev;
    ev            = '0;
    ev[VALID_BIT] = 1'b1;
    ev[EXT_BIT]   = ext;
    ev[BRK_BIT]   = brk;
    ev[7:0]       = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: small synchronous FIFO for key event words.
//   clk, rst    - clock, synchronous active-high reset (empties the FIFO)
//   push, din   - write request and data; ignored when full unless popping
//   pop         - read request; head advances, ignored when empty
//   head        - oldest entry
//   full, empty - occupancy flags
module ps2_event_fifo
  import ps2_kb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_kb_writer.sv
// ps2_kb_writer: receives PS/2 keyboard frames, decodes scan codes (E0/F0
// prefixes), buffers key events and writes each into a mailbox word once the
// CPU has cleared it.
//   clk, rst          - system clock, synchronous active-high reset
//   ps2_clk, ps2_data - raw asynchronous PS/2 lines
//   code_key          - mailbox readback (combinational read of addr_kb)
//   we_kb/addr_kb/data_kb - mailbox write port
//   frame_err         - one-cycle pulse on parity/stop/timeout error
//   overflow          - one-cycle pulse when an event is dropped (FIFO full)
// Build option: PS2_BREAK_FILTER_EN - bytes after an F0 prefix produce no event.
//
// Receiver states:
//   RX_IDLE   | waiting for start bit (data low on falling edge)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | capturing the parity bit
//   RX_STOP   | checking odd parity and stop bit
// Writer states:
//   W_IDLE    | waiting for an event and an empty (zero) mailbox
//   W_HOLD    | write in flight; lets it appear on code_key before re-checking
module ps2_kb_writer
  import ps2_kb_pkg::*;
#(
  parameter logic [31:0] KB_ADDR        = 32'h0000_00F0,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] code_key,
  output logic        we_kb,
  output logic [31:0] addr_kb,
  output logic [31:0] data_kb,
  output logic        frame_err,
  output logic        overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  pclk_sync_q, pclk_sync_d;
  logic [1:0]  pdat_sync_q, pdat_sync_d;
  logic        pclk_prev_q, pclk_prev_d;
  rx_state_t   rx_q, rx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        frame_err_q, frame_err_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic        overflow_q, overflow_d;
  wr_state_t   wr_q, wr_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d;

  logic        fall, bit_in, byte_ok, push, pop, fifo_full, fifo_empty;
  logic [31:0] fifo_head;

  assign fall   = pclk_prev_q && !pclk_sync_q[1];
  assign bit_in = pdat_sync_q[1];

  // Receiver, timeout and synchronizers
  always_comb begin
    pclk_sync_d = {pclk_sync_q[0], ps2_clk};
    pdat_sync_d = {pdat_sync_q[0], ps2_data};
    pclk_prev_d = pclk_sync_q[1];
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;

    if (fall)                to_cnt_d = TW'(TIMEOUT_CYCLES);
    else if (to_cnt_q != '0) to_cnt_d = to_cnt_q - TW'(1);
    else                     to_cnt_d = to_cnt_q;

    case (rx_q)
      RX_IDLE: if (fall && !bit_in) begin
        rx_d      = RX_DATA;
        bit_cnt_d = '0;
      end
      RX_DATA: if (fall) begin
        shreg_d   = {bit_in, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) rx_d = RX_PARITY;
      end
      RX_PARITY: if (fall) begin
        parity_d = bit_in;
        rx_d     = RX_STOP;
      end
      RX_STOP: if (fall) begin
        rx_d = RX_IDLE;
        if ((^{shreg_q, parity_q}) && bit_in) byte_ok     = 1'b1;
        else                                  frame_err_d = 1'b1;
      end
      default: rx_d = RX_IDLE;
    endcase

    if (rx_q != RX_IDLE && !fall && to_cnt_q == '0) begin
      rx_d        = RX_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // Prefix decode and event push
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    push       = 1'b0;
    if (byte_ok) begin
      if (shreg_q == EXT_PREFIX) begin
        ext_d = 1'b1;
      end else if (shreg_q == BREAK_PREFIX) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        push  = !brk_q;
`else
        push  = 1'b1;
`endif
      end
    end
    overflow_d = push && fifo_full && !pop;
  end

  // Mailbox writer
  always_comb begin
    wr_d   = wr_q;
    we_d   = 1'b0;
    data_d = data_q;
    pop    = 1'b0;
    case (wr_q)
      W_IDLE: if (!fifo_empty && code_key == '0) begin
        we_d   = 1'b1;
        data_d = fifo_head;
        pop    = 1'b1;
        wr_d   = W_HOLD;
      end
      W_HOLD:  wr_d = W_IDLE;
      default: wr_d = W_IDLE;
    endcase
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (make_event(ext_q, brk_q, shreg_q)),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sync_q <= 2'b11;
      pdat_sync_q <= 2'b11;
      pclk_prev_q <= 1'b1;
      rx_q        <= RX_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= TW'(TIMEOUT_CYCLES);
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= W_IDLE;
      we_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      pclk_sync_q <= pclk_sync_d;
      pdat_sync_q <= pdat_sync_d;
      pclk_prev_q <= pclk_prev_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      we_q        <= we_d;
      data_q      <= data_d;
    end
  end

  assign we_kb     = we_q;
  assign addr_kb   = KB_ADDR;
  assign data_kb   = data_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_kb_writer.sv
module tb_ps2_kb_writer;

  localparam int TO   = 300;
  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] code_key;
  logic        we_kb, frame_err, overflow;
  logic [31:0] addr_kb, data_kb;

  logic [31:0] mem;
  logic        hold_busy = 1'b0;
  logic        auto_clr = 1'b1;

  int checks = 0, passes = 0;
  int err_cnt = 0, ovf_cnt = 0, wr_cnt = 0;
  logic [31:0] exp_q[$];

  ps2_kb_writer #(.KB_ADDR(32'h0000_00F0), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_key(code_key), .we_kb(we_kb), .addr_kb(addr_kb), .data_kb(data_kb),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Mailbox word in data memory, with an optional CPU that clears it.
  always @(posedge clk) begin
    if (rst)                         mem <= '0;
    else if (we_kb)                  mem <= data_kb;
    else if (auto_clr && mem != '0)  mem <= '0;
  end
  assign code_key = hold_busy ? 32'h8000_0001 : mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (overflow)  ovf_cnt++;
      if (we_kb) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got data_kb=%h expected no write", data_kb);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("write_data", data_kb, e);
          chk("write_addr", addr_kb, 32'h0000_00F0);
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip);
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(b[k]);
    send_bit((~^b) ^ flip);
    send_bit(1'b1);
    ps2_data = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [23:0] bytes;    // first byte in [7:0]
    int          n;
    bit          flip_last;
    logic [31:0] exp;
    bit          exp_wr;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int e0, w0, o0;
    bit ew;
    logic [7:0] b;

    vecs[0] = '{24'h00001C, 1, 1'b0, 32'h8000_001C, 1'b1, 1'b0};
    vecs[1] = '{24'h001CF0, 2, 1'b0, 32'h8000_011C, 1'b1, 1'b0};
    vecs[2] = '{24'h0075E0, 2, 1'b0, 32'h8000_0275, 1'b1, 1'b0};
    vecs[3] = '{24'h75F0E0, 3, 1'b0, 32'h8000_0375, 1'b1, 1'b0};
    vecs[4] = '{24'h00001C, 1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[5] = '{24'h00001C, 1, 1'b0, 32'h8000_001C, 1'b1, 1'b0};
    vecs[6] = '{24'h00005A, 1, 1'b0, 32'h8000_005A, 1'b1, 1'b0};

    repeat (5) @(negedge clk);
    chk("rst_we_kb", 32'(we_kb), 32'd0);
    chk("rst_data_kb", data_kb, 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_addr_kb", addr_kb, 32'h0000_00F0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      e0 = err_cnt;
      w0 = wr_cnt;
      ew = vecs[i].exp_wr;
`ifdef PS2_BREAK_FILTER_EN
      if (vecs[i].exp[8]) ew = 1'b0;
`endif
      if (ew) exp_q.push_back(vecs[i].exp);
      for (int j = 0; j < vecs[i].n; j++) begin
        b = vecs[i].bytes[8*j +: 8];
        send_byte(b, vecs[i].flip_last && (j == vecs[i].n - 1));
      end
      wait_drain($sformatf("vec%0d_drain", i));
      chk($sformatf("vec%0d_frame_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_writes", i), 32'(wr_cnt - w0), 32'(ew));
    end

    // Mailbox busy: four events buffered, fifth dropped, then drained in order.
    o0 = ovf_cnt;
    w0 = wr_cnt;
    hold_busy = 1'b1;
    exp_q.push_back(32'h8000_0015);
    exp_q.push_back(32'h8000_001D);
    exp_q.push_back(32'h8000_0024);
    exp_q.push_back(32'h8000_002D);
    send_byte(8'h15, 1'b0);
    send_byte(8'h1D, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h2D, 1'b0);
    chk("busy_no_overflow_yet", 32'(ovf_cnt - o0), 32'd0);
    send_byte(8'h2C, 1'b0);
    repeat (20) @(negedge clk);
    chk("busy_overflow", 32'(ovf_cnt - o0), 32'd1);
    chk("busy_no_write", 32'(wr_cnt - w0), 32'd0);
    hold_busy = 1'b0;
    wait_drain("busy_drain");
    chk("busy_writes", 32'(wr_cnt - w0), 32'd4);

    // Partial frame then silence: timeout abort, next frame clean.
    e0 = err_cnt;
    w0 = wr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    chk("timeout_early", 32'(err_cnt - e0), 32'd0);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_err", 32'(err_cnt - e0), 32'd1);
    exp_q.push_back(32'h8000_0029);
    send_byte(8'h29, 1'b0);
    wait_drain("after_timeout_drain");
    chk("after_timeout_err", 32'(err_cnt - e0), 32'd1);
    chk("after_timeout_writes", 32'(wr_cnt - w0), 32'd1);

    // Reset mid-frame aborts the partial byte.
    w0 = wr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h8000_0016);
    send_byte(8'h16, 1'b0);
    wait_drain("after_reset_drain");
    chk("after_reset_writes", 32'(wr_cnt - w0), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
